// File: rtl/float_multiplier_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : float_multiplier_pipelined
// Purpose  : Parametrised floating-point multiplier {sign, EXP_W exp, MAN_W man}
//            with a three-register pipeline (classify -> multiply ->
//            normalise/round/pack) and valid/ready handshakes on both sides.
//            Subnormal inputs are flushed to zero; no subnormal outputs.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high; drops all in-flight results
//   in_valid   in   operand pair valid
//   in_ready   out  operands accepted this cycle when in_valid is high
//   a, b       in   operands {sign, exp, man}
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   y          out  product
//   flags      out  {invalid, overflow, underflow, inexact}, aligned with y
// ============================================================================
module float_multiplier_pipelined #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 7,
  parameter int BIAS     = 127,
  parameter int SAT_MODE = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW1 = MAN_W + 1;          // mantissa with hidden bit
  localparam int PW  = 2 * MAN_W + 2;      // full product width
  localparam int EW2 = EXP_W + 2;          // signed working exponent width

  localparam logic signed [EW2-1:0] BIAS_E   = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EMAX_E   = EW2'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]      EXP_MAXF = EXP_ONES - 1'b1;
  localparam logic [MAN_W-1:0]      MAN_ONES = {MAN_W{1'b1}};
  localparam logic [MAN_W-1:0]      MAN_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    KIND_NUM  = 2'd0,
    KIND_NAN  = 2'd1,
    KIND_INF  = 2'd2,
    KIND_ZERO = 2'd3
  } kind_t;

  // ---------------------------------------------------------------- state
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q,  s1_sign_d;
  logic signed [EW2-1:0] s1_exp_q,   s1_exp_d;
  logic [MW1-1:0]        s1_man_a_q, s1_man_a_d;
  logic [MW1-1:0]        s1_man_b_q, s1_man_b_d;
  kind_t                 s1_kind_q,  s1_kind_d;

  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_sign_q,  s2_sign_d;
  logic signed [EW2-1:0] s2_exp_q,   s2_exp_d;
  logic [PW-1:0]         s2_prod_q,  s2_prod_d;
  kind_t                 s2_kind_q,  s2_kind_d;

  logic                  out_valid_q, out_valid_d;
  logic [W-1:0]          y_q,         y_d;
  logic [3:0]            flags_q,     flags_d;

  // Whole pipeline moves as one: bubbles shift like data, nothing compacts.
  logic adv;
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;

  // ------------------------------------------------------ stage 1: classify
  logic [EXP_W-1:0]      a_exp, b_exp;
  logic [MAN_W-1:0]      a_man, b_man;
  logic                  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic signed [EW2-1:0] exp_sum;
  kind_t                 in_kind;

  assign a_exp  = a[W-2:MAN_W];
  assign b_exp  = b[W-2:MAN_W];
  assign a_man  = a[MAN_W-1:0];
  assign b_man  = b[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_man == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_man != '0);

  assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_E;

  // Special classes in priority order; the arithmetic path is only used
  // for KIND_NUM but is still computed so the datapath stays uniform.
  always_comb begin
    in_kind = KIND_NUM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      in_kind = KIND_NAN;
    end else if (a_inf || b_inf) begin
      in_kind = KIND_INF;
    end else if (a_zero || b_zero) begin
      in_kind = KIND_ZERO;
    end
  end

  // ------------------------------------------- stage 3: normalise and round
  logic [W-2:0] ovf_mag;

  generate
    if (SAT_MODE != 0) begin : g_sat
      assign ovf_mag = {EXP_MAXF, MAN_ONES};
    end else begin : g_inf
      assign ovf_mag = {EXP_ONES, {MAN_W{1'b0}}};
    end
  endgenerate

  logic [PW-2:0]         norm;
  logic                  rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_up;
  logic [MW1-1:0]        man_rnd;
  logic                  man_carry;
  logic [MAN_W-1:0]      man_fin;
  logic signed [EW2-1:0] exp_fin;
  logic [W-1:0]          s3_y;
  logic [3:0]            s3_flags;

  always_comb begin
    // Product is in [1,4): a set MSB means it is >= 2 and the exponent
    // gains one; otherwise drop the leading zero by shifting left.
    norm      = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    rnd_lsb   = norm[MAN_W+1];
    rnd_g     = norm[MAN_W];
    rnd_r     = norm[MAN_W-1];
    rnd_s     = |norm[MAN_W-2:0];
    rnd_up    = rnd_g && (rnd_r || rnd_s || rnd_lsb);
    man_rnd   = {1'b0, norm[PW-2:MAN_W+1]} + MW1'(rnd_up);
    man_carry = man_rnd[MAN_W];
    man_fin   = man_carry ? '0 : man_rnd[MAN_W-1:0];
    exp_fin   = s2_exp_q + EW2'(s2_prod_q[PW-1]) + EW2'(man_carry);

    s3_y     = '0;
    s3_flags = '0;
    case (s2_kind_q)
      KIND_NAN: begin
        s3_y     = {1'b0, EXP_ONES, MAN_QNAN};
        s3_flags = 4'b1000;
      end
      KIND_INF:  s3_y = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
      KIND_ZERO: s3_y = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (exp_fin >= EMAX_E) begin
          s3_y     = {s2_sign_q, ovf_mag};
          s3_flags = 4'b0101;
        end else if (exp_fin[EW2-1] || (exp_fin == '0)) begin
          s3_y     = {s2_sign_q, {(W-1){1'b0}}};
          s3_flags = 4'b0011;
        end else begin
          s3_y     = {s2_sign_q, exp_fin[EXP_W-1:0], man_fin};
          s3_flags = {3'b000, rnd_g || rnd_r || rnd_s};
        end
      end
    endcase
  end

  // ----------------------------------------------------- next-state logic
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_man_a_d  = s1_man_a_q;
    s1_man_b_d  = s1_man_b_q;
    s1_kind_d   = s1_kind_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_exp_d    = s2_exp_q;
    s2_prod_d   = s2_prod_q;
    s2_kind_d   = s2_kind_q;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    flags_d     = flags_q;

    if (adv) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      // Payload registers only load behind a valid beat.
      if (in_valid) begin
        s1_sign_d  = a[W-1] ^ b[W-1];
        s1_exp_d   = exp_sum;
        s1_man_a_d = {1'b1, a_man};
        s1_man_b_d = {1'b1, b_man};
        s1_kind_d  = in_kind;
      end
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_exp_d  = s1_exp_q;
        s2_prod_d = PW'(s1_man_a_q) * PW'(s1_man_b_q);
        s2_kind_d = s1_kind_q;
      end
      if (s2_valid_q) begin
        y_d     = s3_y;
        flags_d = s3_flags;
      end
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_man_a_q  <= '0;
      s1_man_b_q  <= '0;
      s1_kind_q   <= KIND_NUM;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_prod_q   <= '0;
      s2_kind_q   <= KIND_NUM;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_man_a_q  <= s1_man_a_d;
      s1_man_b_q  <= s1_man_b_d;
      s1_kind_q   <= s1_kind_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_exp_q    <= s2_exp_d;
      s2_prod_q   <= s2_prod_d;
      s2_kind_q   <= s2_kind_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_float_multiplier_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_multiplier_pipelined
// Purpose  : Self-checking bench. A bf16 instance and a saturating bf16
//            instance share stimulus; a third e4m3-like instance is driven
//            separately. Expected values come from directed constants and an
//            integer-arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_float_multiplier_pipelined;

  logic        clock = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [15:0] a, b;
  logic        in_ready, out_valid, in_ready_s, out_valid_s;
  logic [15:0] y, y_s;
  logic [3:0]  flags, flags_s;

  logic        e_in_valid, e_out_ready, e_in_ready, e_out_valid;
  logic [7:0]  e_a, e_b, e_y;
  logic [3:0]  e_flags;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  float_multiplier_pipelined #(.EXP_W(8), .MAN_W(7), .BIAS(127), .SAT_MODE(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .flags(flags));

  float_multiplier_pipelined #(.EXP_W(8), .MAN_W(7), .BIAS(127), .SAT_MODE(1)) dut_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .flags(flags_s));

  float_multiplier_pipelined #(.EXP_W(4), .MAN_W(3), .BIAS(7), .SAT_MODE(0)) dut_e4 (
    .clock(clock), .reset(reset), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .a(e_a), .b(e_b), .out_valid(e_out_valid), .out_ready(e_out_ready), .y(e_y), .flags(e_flags));

  // Reference: exact integer product, round-half-even on the remainder.
  // Returns {flags, y} with y right-aligned in 16 bits.
  function automatic logic [19:0] ref_mul(input int ew, input int mw, input int sat,
                                          input logic [15:0] a_in, input logic [15:0] b_in);
    int emax, bias, ai, bi, sa, sb, ea, eb, fa, fb, s, e, sh;
    longint p, q, rem, half;
    logic [15:0] ry;
    logic [3:0]  rf;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    ai = int'(a_in);
    bi = int'(b_in);
    sa = (ai >> (ew + mw)) & 1;  sb = (bi >> (ew + mw)) & 1;
    ea = (ai >> mw) & emax;      eb = (bi >> mw) & emax;
    fa = ai & ((1 << mw) - 1);   fb = bi & ((1 << mw) - 1);
    s  = sa ^ sb;
    rf = 4'b0000;
    ry = 16'h0000;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0) ||
        (ea == emax && eb == 0) || (ea == 0 && eb == emax)) begin
      ry = 16'((emax << mw) | (1 << (mw - 1)));
      rf = 4'b1000;
    end else if (ea == emax || eb == emax) begin
      ry = 16'((s << (ew + mw)) | (emax << mw));
    end else if (ea == 0 || eb == 0) begin
      ry = 16'(s << (ew + mw));
    end else begin
      p  = longint'(fa + (1 << mw)) * longint'(fb + (1 << mw));
      sh = (p >= (longint'(1) << (2 * mw + 1))) ? mw + 1 : mw;
      q  = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      e = ea + eb - bias + (sh - mw);
      if (q == (longint'(1) << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= emax) begin
        rf = 4'b0101;
        if (sat != 0) ry = 16'((s << (ew + mw)) | ((emax - 1) << mw) | ((1 << mw) - 1));
        else          ry = 16'((s << (ew + mw)) | (emax << mw));
      end else if (e <= 0) begin
        rf = 4'b0011;
        ry = 16'(s << (ew + mw));
      end else begin
        ry = 16'((s << (ew + mw)) | (e << mw) | int'(q - (longint'(1) << mw)));
        rf = {3'b000, rem != 0};
      end
    end
    return {rf, ry};
  endfunction

  // Random bf16 operand biased towards specials and near-unity exponents.
  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0:       v[14:7] = 8'h00;
      1:       v[14:7] = 8'hFF;
      2, 3:    v[14:7] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return v;
  endfunction

  // Single isolated operation on the bf16 pair; lat counts rising edges
  // from the accepting edge (inclusive) until out_valid is seen.
  task automatic run_one(input logic [15:0] ia, input logic [15:0] ib,
                         output logic [15:0] oy, output logic [3:0] of,
                         output logic [15:0] oys, output logic [3:0] ofs, output int lat);
    @(negedge clock);
    a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    oy = y; of = flags; oys = y_s; ofs = flags_s;
  endtask

  task automatic run_e4(input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] oy, output logic [3:0] of, output logic ok);
    int k;
    @(negedge clock);
    e_a = ia; e_b = ib; e_in_valid = 1'b1; e_out_ready = 1'b1;
    @(negedge clock);
    e_in_valid = 1'b0;
    k = 0;
    while (!e_out_valid && k < 20) begin
      @(negedge clock);
      k++;
    end
    ok = e_out_valid;
    oy = e_y; of = e_flags;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if ({out_valid, y, flags} !== 21'd0) $display("FAIL reset_state: got %h required 0", {out_valid, y, flags});
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else pass_cnt++;
  endtask

  logic [15:0] d_a  [10] = '{16'h3FC0, 16'h3FC0, 16'h3F81, 16'h7F00, 16'h0080,
                             16'h7F80, 16'hFF80, 16'h8000, 16'h7FC1, 16'hC000};
  logic [15:0] d_b  [10] = '{16'h3FC0, 16'h3F81, 16'h3F81, 16'h4000, 16'h3F00,
                             16'h0000, 16'h4000, 16'h3F80, 16'h3F80, 16'h4040};
  logic [15:0] d_y  [10] = '{16'h4010, 16'h3FC2, 16'h3F82, 16'h7F80, 16'h0000,
                             16'h7FC0, 16'hFF80, 16'h8000, 16'h7FC0, 16'hC0C0};
  logic [15:0] d_ys [10] = '{16'h4010, 16'h3FC2, 16'h3F82, 16'h7F7F, 16'h0000,
                             16'h7FC0, 16'hFF80, 16'h8000, 16'h7FC0, 16'hC0C0};
  logic [3:0]  d_f  [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0101, 4'b0011,
                             4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};

  task automatic test_directed();
    logic [15:0] ry, rys;
    logic [3:0]  rf, rfs;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_one(d_a[i], d_b[i], ry, rf, rys, rfs, lat);
      total_cnt += 5;
      if (lat != 3) $display("FAIL dir%0d_latency: got %0d required 3", i, lat); else pass_cnt++;
      if (ry !== d_y[i]) $display("FAIL dir%0d_y: got %h required %h", i, ry, d_y[i]); else pass_cnt++;
      if (rf !== d_f[i]) $display("FAIL dir%0d_flags: got %b required %b", i, rf, d_f[i]); else pass_cnt++;
      if (rys !== d_ys[i]) $display("FAIL dir%0d_sat_y: got %h required %h", i, rys, d_ys[i]); else pass_cnt++;
      if (rfs !== d_f[i]) $display("FAIL dir%0d_sat_flags: got %b required %b", i, rfs, d_f[i]); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pa [5];
    logic [15:0] pb [5];
    logic [19:0] ex [5];
    int idx, got;
    for (int i = 0; i < 5; i++) begin
      pa[i] = rnd_op(); pb[i] = rnd_op();
      ex[i] = ref_mul(8, 7, 0, pa[i], pb[i]);
    end
    idx = 0;
    @(negedge clock);
    out_ready = 1'b0;
    repeat (8) begin
      @(negedge clock);
      in_valid = (idx < 5);
      a = pa[idx < 5 ? idx : 4]; b = pb[idx < 5 ? idx : 4];
      #1;
      if (in_valid && in_ready) idx++;
    end
    total_cnt += 2;
    if (idx != 3) $display("FAIL bp_accepted: got %0d required 3", idx); else pass_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", in_ready); else pass_cnt++;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clock);
      out_ready = 1'b1;
      in_valid = (idx < 5);
      a = pa[idx < 5 ? idx : 4]; b = pb[idx < 5 ? idx : 4];
      #1;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        total_cnt++;
        if ({flags, y} !== ex[got]) $display("FAIL bp_result%0d: got %h required %h", got, {flags, y}, ex[got]);
        else pass_cnt++;
        got++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (got != 5) $display("FAIL bp_count: got %0d required 5", got); else pass_cnt++;
    repeat (4) @(negedge clock);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_extra: got %b required 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [39:0] q [$];
    logic [39:0] e;
    logic        held;
    logic [19:0] held_v;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; held = 1'b0; held_v = '0;
    while (recv < N && cyc < 60000) begin
      @(negedge clock);
      cyc++;
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      a = rnd_op(); b = rnd_op();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held) begin
        total_cnt++;
        if ({out_valid, flags, y} !== {1'b1, held_v})
          $display("FAIL rnd_stall_hold: got %h required %h", {out_valid, flags, y}, {1'b1, held_v});
        else pass_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back({ref_mul(8, 7, 0, a, b), ref_mul(8, 7, 1, a, b)});
        sent++;
      end
      if (out_valid && out_ready) begin
        total_cnt++;
        if (q.size() == 0) begin
          $display("FAIL rnd_unexpected_output: got %h required none", {flags, y});
        end else begin
          e = q.pop_front();
          if ({flags, y} !== e[39:20] || {out_valid_s, flags_s, y_s} !== {1'b1, e[19:0]})
            $display("FAIL rnd_result%0d: got %h/%h required %h/%h", recv, {flags, y}, {flags_s, y_s}, e[39:20], e[19:0]);
          else pass_cnt++;
        end
        recv++;
      end
      held   = out_valid && !out_ready;
      held_v = {flags, y};
    end
    in_valid = 1'b0;
    total_cnt++;
    if (recv != N) $display("FAIL rnd_timeout: got %0d results required %0d", recv, N); else pass_cnt++;
  endtask

  task automatic test_midreset();
    logic seen;
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h3FC0; b = 16'h3FC0;
    @(negedge clock);
    a = 16'h4000;
    @(negedge clock);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clock);
    #1;
    total_cnt++;
    if ({out_valid, y, flags} !== 21'd0) $display("FAIL midreset_flush: got %h required 0", {out_valid, y, flags});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen = seen | out_valid;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL midreset_stale: got %b required 0", seen); else pass_cnt++;
  endtask

  task automatic test_e4m3();
    logic [7:0]  ry, ta, tb_op;
    logic [3:0]  rf;
    logic        ok;
    logic [19:0] ex;
    run_e4(8'h38, 8'h40, ry, rf, ok);
    total_cnt++;
    if ({ok, rf, ry} !== {1'b1, 4'b0000, 8'h40}) $display("FAIL e4_one_x_two: got %h required %h", {ok, rf, ry}, {1'b1, 4'b0000, 8'h40});
    else pass_cnt++;
    run_e4(8'h39, 8'h39, ry, rf, ok);
    total_cnt++;
    if ({ok, rf, ry} !== {1'b1, 4'b0001, 8'h3A}) $display("FAIL e4_round: got %h required %h", {ok, rf, ry}, {1'b1, 4'b0001, 8'h3A});
    else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      ta = 8'($urandom); tb_op = 8'($urandom);
      ex = ref_mul(4, 3, 0, {8'h00, ta}, {8'h00, tb_op});
      run_e4(ta, tb_op, ry, rf, ok);
      total_cnt++;
      if ({ok, rf, ry} !== {1'b1, ex[19:16], ex[7:0]})
        $display("FAIL e4_rnd%0d: %h x %h got %h required %h", i, ta, tb_op, {ok, rf, ry}, {1'b1, ex[19:16], ex[7:0]});
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    e_in_valid = 1'b0; e_out_ready = 1'b1; e_a = '0; e_b = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_midreset();
    test_e4m3();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
